// File: rtl/wb_initiator_pkg.sv
// Shared types and constants for the Wishbone classic-cycle initiator.
package wb_initiator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    REQ   = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam logic [WB_AW-1:0] ADR_STEP = 32'd4;

endpackage

// File: rtl/wb_initiator_timer.sv
// Strobe-wait counter: counts cycles while enabled, clears on request, and
// flags the cycle on which the wait reaches TIMEOUT (TIMEOUT = 0 never fires).
module wb_initiator_timer #(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic hit_o
);

  localparam bit                   ENABLED = (TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] LIMIT   = ENABLED ? TIMEOUT_W'(TIMEOUT - 1) : '0;

  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_d;

  // Next count: clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = ENABLED && en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic-cycle initiator: turns a command/write-data stream into
// single or incrementing-burst bus cycles and reports on a response channel.
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int LEN_W     = 8,
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic             io_wbs_clk,
  input  logic             io_wbs_rst_n,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [WB_AW-1:0] cmd_adr_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic [3:0]       cmd_sel_i,
  input  logic             wdata_valid_i,
  output logic             wdata_ready_o,
  input  logic [WB_DW-1:0] wdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WB_DW-1:0] rsp_data_o,
  output logic             rsp_last_o,
  output logic             rsp_err_o,
  output logic             busy_o,
  output logic             io_wbm_cyc_o,
  output logic             io_wbm_stb_o,
  output logic             io_wbm_we_o,
  output logic [WB_AW-1:0] io_wbm_adr_o,
  output logic [WB_DW-1:0] io_wbm_datwr_o,
  output logic [3:0]       io_wbm_sel_o,
  input  logic [WB_DW-1:0] io_wbm_datrd_i,
  input  logic             io_wbm_ack_i
);

  state_e             state_q, state_d;
  logic               we_q, we_d;
  logic [WB_AW-1:0]   adr_q, adr_d;
  logic [3:0]         sel_q, sel_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [WB_DW-1:0]   datwr_q, datwr_d;
  logic [WB_DW-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_last_q, rsp_last_d;
  logic               rsp_err_q, rsp_err_d;
  logic               cyc_q, cyc_d;
  logic               stb_q, stb_d;
  logic               busy_q, busy_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               wdata_ready_q, wdata_ready_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               tmr_hit;
  logic               more_beats;

  assign more_beats = (cnt_q != {LEN_W{1'b0}});

  wb_initiator_timer #(
    .TIMEOUT   (TIMEOUT),
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timer (
    .clk   (io_wbs_clk),
    .rst_n (io_wbs_rst_n),
    .en_i  (stb_q),
    .clr_i (!stb_q || io_wbm_ack_i),
    .hit_o (tmr_hit)
  );

  // Next-state and next-output logic; handshake outputs follow the next state.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    adr_d      = adr_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    datwr_d    = datwr_q;
    rsp_data_d = rsp_data_q;
    rsp_last_d = rsp_last_q;
    rsp_err_d  = rsp_err_q;
    cyc_d      = cyc_q;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          we_d       = cmd_we_i;
          adr_d      = cmd_adr_i;
          sel_d      = cmd_sel_i;
          cnt_d      = cmd_len_i;
          cyc_d      = 1'b1;
          busy_d     = 1'b1;
          rsp_err_d  = 1'b0;
          rsp_last_d = 1'b0;
          rsp_data_d = '0;
          state_d    = cmd_we_i ? WDATA : REQ;
        end else begin
          state_d = IDLE;
        end
      end
      WDATA: begin
        if (wdata_valid_i && wdata_ready_q) begin
          datwr_d = wdata_i;
          state_d = REQ;
        end else begin
          state_d = WDATA;
        end
      end
      REQ: begin
        // An ack on the timeout cycle still completes the beat normally.
        if (io_wbm_ack_i && stb_q) begin
          if (!we_q) begin
            rsp_data_d = io_wbm_datrd_i;
            rsp_last_d = !more_beats;
            state_d    = RESP;
          end else if (more_beats) begin
            cnt_d   = cnt_q - LEN_W'(1);
            adr_d   = adr_q + ADR_STEP;
            state_d = WDATA;
          end else begin
            rsp_data_d = '0;
            rsp_last_d = 1'b1;
            state_d    = RESP;
          end
        end else if (tmr_hit) begin
          cyc_d      = 1'b0;
          rsp_err_d  = 1'b1;
          rsp_last_d = 1'b1;
          rsp_data_d = '0;
          state_d    = RESP;
        end else begin
          state_d = REQ;
        end
      end
      RESP: begin
        if (rsp_ready_i && rsp_valid_q) begin
          if (!rsp_err_q && !we_q && more_beats) begin
            cnt_d   = cnt_q - LEN_W'(1);
            adr_d   = adr_q + ADR_STEP;
            state_d = REQ;
          end else begin
            cyc_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    stb_d         = (state_d == REQ);
    rsp_valid_d   = (state_d == RESP);
    wdata_ready_d = (state_d == WDATA);
    cmd_ready_d   = (state_d == IDLE);
  end

  // State and registered outputs; reset aborts any cycle silently.
  always_ff @(posedge io_wbs_clk) begin
    if (!io_wbs_rst_n) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      adr_q         <= '0;
      sel_q         <= 4'd0;
      cnt_q         <= '0;
      datwr_q       <= '0;
      rsp_data_q    <= '0;
      rsp_last_q    <= 1'b0;
      rsp_err_q     <= 1'b0;
      cyc_q         <= 1'b0;
      stb_q         <= 1'b0;
      busy_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      wdata_ready_q <= 1'b0;
      cmd_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      adr_q         <= adr_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      datwr_q       <= datwr_d;
      rsp_data_q    <= rsp_data_d;
      rsp_last_q    <= rsp_last_d;
      rsp_err_q     <= rsp_err_d;
      cyc_q         <= cyc_d;
      stb_q         <= stb_d;
      busy_q        <= busy_d;
      rsp_valid_q   <= rsp_valid_d;
      wdata_ready_q <= wdata_ready_d;
      cmd_ready_q   <= cmd_ready_d;
    end
  end

  assign cmd_ready_o    = cmd_ready_q;
  assign wdata_ready_o  = wdata_ready_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_last_o     = rsp_last_q;
  assign rsp_err_o      = rsp_err_q;
  assign busy_o         = busy_q;
  assign io_wbm_cyc_o   = cyc_q;
  assign io_wbm_stb_o   = stb_q;
  assign io_wbm_we_o    = we_q;
  assign io_wbm_adr_o   = adr_q;
  assign io_wbm_datwr_o = datwr_q;
  assign io_wbm_sel_o   = sel_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator with a small scripted Wishbone responder.
module tb_wb_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr;
  logic [7:0]  cmd_len;
  logic [3:0]  cmd_sel;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic        rsp_valid, rsp_ready, rsp_last, rsp_err, busy;
  logic [31:0] rsp_data;
  logic        cyc, stb, we, ack;
  logic [31:0] adr, datwr, datrd;
  logic [3:0]  sel;

  int n_cmp = 0;
  int n_bad = 0;

  // Responder controls and logs
  int          ack_after = 1;
  bit          force_ack = 1'b0;
  bit          rd_fixed_en = 1'b0;
  logic [31:0] rd_fixed = 32'h0;
  int          stb_cycles = 0;
  int          adr_changes = 0;
  int          cyc_drops = 0;
  logic [31:0] q_adr[$];
  logic [31:0] q_dat[$];
  logic [3:0]  q_sel[$];
  logic        q_we[$];

  always #5 clk = ~clk;

  wb_initiator #(.LEN_W(8), .TIMEOUT(8), .TIMEOUT_W(8)) dut (
    .io_wbs_clk     (clk),
    .io_wbs_rst_n   (rst_n),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_we_i       (cmd_we),
    .cmd_adr_i      (cmd_adr),
    .cmd_len_i      (cmd_len),
    .cmd_sel_i      (cmd_sel),
    .wdata_valid_i  (wdata_valid),
    .wdata_ready_o  (wdata_ready),
    .wdata_i        (wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_data_o     (rsp_data),
    .rsp_last_o     (rsp_last),
    .rsp_err_o      (rsp_err),
    .busy_o         (busy),
    .io_wbm_cyc_o   (cyc),
    .io_wbm_stb_o   (stb),
    .io_wbm_we_o    (we),
    .io_wbm_adr_o   (adr),
    .io_wbm_datwr_o (datwr),
    .io_wbm_sel_o   (sel),
    .io_wbm_datrd_i (datrd),
    .io_wbm_ack_i   (ack)
  );

  // Responder: acks the ack_after-th stb cycle; read data is ~adr unless fixed.
  initial begin : responder
    int          wait_cnt;
    logic        prev_stb;
    logic [31:0] prev_adr;
    wait_cnt = 0;
    prev_stb = 1'b0;
    prev_adr = 32'h0;
    ack = 1'b0;
    datrd = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (stb === 1'b1) stb_cycles++;
      if (stb === 1'b1 && prev_stb && adr !== prev_adr) adr_changes++;
      if (busy === 1'b1 && cyc !== 1'b1 && rsp_err !== 1'b1) cyc_drops++;
      prev_stb = (stb === 1'b1);
      prev_adr = adr;
      if (force_ack) begin
        ack = 1'b1;
        wait_cnt = 0;
      end else if (stb === 1'b1) begin
        wait_cnt++;
        if (ack_after != 0 && wait_cnt == ack_after) begin
          ack = 1'b1;
          datrd = rd_fixed_en ? rd_fixed : ~adr;
          q_adr.push_back(adr);
          q_dat.push_back(datwr);
          q_sel.push_back(sel);
          q_we.push_back(we);
          wait_cnt = 0;
        end else begin
          ack = 1'b0;
        end
      end else begin
        ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    stb_cycles = 0;
    adr_changes = 0;
    cyc_drops = 0;
    q_adr.delete();
    q_dat.delete();
    q_sel.delete();
    q_we.delete();
  endtask

  task automatic issue_cmd(input logic w, input logic [31:0] a, input logic [7:0] l, input logic [3:0] s);
    int i;
    cmd_valid = 1'b1;
    cmd_we = w;
    cmd_adr = a;
    cmd_len = l;
    cmd_sel = s;
    for (i = 0; i < 50 && cmd_ready !== 1'b1; i++) tick();
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL cmd_accept: cmd_ready got %b required 1", cmd_ready);
      n_bad++;
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic push_wdata(input logic [31:0] d, input int gap);
    int i;
    for (i = 0; i < gap; i++) tick();
    wdata_valid = 1'b1;
    wdata = d;
    for (i = 0; i < 50 && wdata_ready !== 1'b1; i++) tick();
    n_cmp++;
    if (wdata_ready !== 1'b1) begin
      $display("FAIL wdata_accept: wdata_ready got %b required 1", wdata_ready);
      n_bad++;
    end
    tick();
    wdata_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [31:0] d, output logic l, output logic e, output logic c);
    int i;
    for (i = 0; i < 200 && rsp_valid !== 1'b1; i++) tick();
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      $display("FAIL rsp_wait: rsp_valid got %b required 1", rsp_valid);
      n_bad++;
    end
    d = rsp_data;
    l = rsp_last;
    e = rsp_err;
    c = cyc;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({cyc, stb, we, rsp_valid, busy, wdata_ready, cmd_ready, rsp_last, rsp_err} !== 9'b0) begin
      $display("FAIL reset_ctrl: got %b required 000000000",
               {cyc, stb, we, rsp_valid, busy, wdata_ready, cmd_ready, rsp_last, rsp_err});
      n_bad++;
    end
    n_cmp++;
    if ({adr, datwr, sel, rsp_data} !== 100'h0) begin
      $display("FAIL reset_data: adr %h datwr %h sel %h rsp_data %h required all 0", adr, datwr, sel, rsp_data);
      n_bad++;
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL idle_ready: cmd_ready got %b required 1", cmd_ready);
      n_bad++;
    end
  endtask

  task automatic test_single_read();
    logic [31:0] d;
    logic l, e, c;
    clear_logs();
    ack_after = 3;
    rd_fixed_en = 1'b1;
    rd_fixed = 32'hDEADBEEF;
    issue_cmd(1'b0, 32'h3000_0010, 8'd0, 4'hF);
    get_rsp(d, l, e, c);
    n_cmp++;
    if ({d, l, e} !== {32'hDEADBEEF, 1'b1, 1'b0}) begin
      $display("FAIL single_read_rsp: data %h last %b err %b required deadbeef 1 0", d, l, e);
      n_bad++;
    end
    n_cmp++;
    if ({cyc, busy, stb} !== 3'b000) begin
      $display("FAIL single_read_end: cyc/busy/stb got %b required 000", {cyc, busy, stb});
      n_bad++;
    end
    n_cmp++;
    if (stb_cycles != 3 || q_adr.size() != 1 || q_adr[0] !== 32'h3000_0010) begin
      $display("FAIL single_read_bus: stb cycles %0d beats %0d required 3 cycles 1 beat at 30000010",
               stb_cycles, q_adr.size());
      n_bad++;
    end
    rd_fixed_en = 1'b0;
  endtask

  task automatic test_latency();
    logic [31:0] d;
    logic l, e, c;
    logic v0;
    ack_after = 1;
    issue_cmd(1'b0, 32'h3000_0020, 8'd0, 4'hF);
    v0 = rsp_valid;
    tick();
    n_cmp++;
    if ({v0, rsp_valid} !== 2'b01) begin
      $display("FAIL read_latency: rsp_valid one/two cycles after accept got %b required 01", {v0, rsp_valid});
      n_bad++;
    end
    get_rsp(d, l, e, c);
    n_cmp++;
    if (d !== ~32'h3000_0020) begin
      $display("FAIL latency_data: got %h required %h", d, ~32'h3000_0020);
      n_bad++;
    end
  endtask

  task automatic test_read_burst();
    logic [31:0] d;
    logic l, e, c;
    int bad_rsp;
    clear_logs();
    ack_after = 2;
    bad_rsp = 0;
    issue_cmd(1'b0, 32'h3000_0000, 8'd3, 4'hF);
    for (int i = 0; i < 4; i++) begin
      get_rsp(d, l, e, c);
      n_cmp++;
      if ({d, l, e} !== {~(32'h3000_0000 + 32'(4 * i)), (i == 3), 1'b0}) begin
        $display("FAIL burst_rsp%0d: data %h last %b err %b required %h %b 0",
                 i, d, l, e, ~(32'h3000_0000 + 32'(4 * i)), (i == 3));
        n_bad++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (i >= q_adr.size() || q_adr[i] !== 32'h3000_0000 + 32'(4 * i)) bad_rsp++;
    end
    n_cmp++;
    if (bad_rsp != 0 || q_adr.size() != 4 || adr_changes != 0 || cyc_drops != 0) begin
      $display("FAIL burst_bus: bad addrs %0d beats %0d adr changes %0d cyc drops %0d required 0 4 0 0",
               bad_rsp, q_adr.size(), adr_changes, cyc_drops);
      n_bad++;
    end
  endtask

  task automatic test_write_burst();
    logic [31:0] d;
    logic l, e, c;
    clear_logs();
    ack_after = 1;
    issue_cmd(1'b1, 32'h3000_0100, 8'd1, 4'h3);
    push_wdata(32'h1111_1111, 2);
    push_wdata(32'h2222_2222, 2);
    get_rsp(d, l, e, c);
    n_cmp++;
    if ({d, l, e} !== {32'h0, 1'b1, 1'b0}) begin
      $display("FAIL write_rsp: data %h last %b err %b required 0 1 0", d, l, e);
      n_bad++;
    end
    n_cmp++;
    if (q_adr.size() != 2 || stb_cycles != 2) begin
      $display("FAIL write_beats: beats %0d stb cycles %0d required 2 2", q_adr.size(), stb_cycles);
      n_bad++;
    end else if ({q_dat[0], q_dat[1], q_sel[0], q_sel[1], q_we[0], q_we[1], q_adr[0], q_adr[1]} !==
                 {32'h1111_1111, 32'h2222_2222, 4'h3, 4'h3, 1'b1, 1'b1, 32'h3000_0100, 32'h3000_0104}) begin
      $display("FAIL write_beats: dat %h %h sel %h %h we %b %b adr %h %h required 11111111 22222222 3 3 1 1 30000100 30000104",
               q_dat[0], q_dat[1], q_sel[0], q_sel[1], q_we[0], q_we[1], q_adr[0], q_adr[1]);
      n_bad++;
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL write_single_rsp: rsp_valid %b busy %b required 0 0", rsp_valid, busy);
      n_bad++;
    end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    logic l, e, c;
    clear_logs();
    ack_after = 0;
    issue_cmd(1'b0, 32'h3000_0200, 8'd3, 4'hF);
    get_rsp(d, l, e, c);
    n_cmp++;
    if ({d, l, e, c} !== {32'h0, 1'b1, 1'b1, 1'b0}) begin
      $display("FAIL timeout_rsp: data %h last %b err %b cyc %b required 0 1 1 0", d, l, e, c);
      n_bad++;
    end
    for (int i = 0; i < 20; i++) tick();
    n_cmp++;
    if (stb_cycles != 8 || cyc !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      $display("FAIL timeout_bus: stb cycles %0d cyc %b busy %b rsp_valid %b required 8 0 0 0",
               stb_cycles, cyc, busy, rsp_valid);
      n_bad++;
    end
  endtask

  task automatic test_back_to_back_wrap();
    logic [31:0] d;
    logic l, e, c;
    int i;
    int stall_bad;
    clear_logs();
    ack_after = 1;
    stall_bad = 0;
    issue_cmd(1'b0, 32'hFFFF_FFFC, 8'd1, 4'hF);
    for (i = 0; i < 50 && rsp_valid !== 1'b1; i++) tick();
    for (i = 0; i < 5; i++) begin
      tick();
      if (stb !== 1'b0 || cyc !== 1'b1 || rsp_valid !== 1'b1) stall_bad++;
    end
    n_cmp++;
    if (stall_bad != 0 || stb_cycles != 1) begin
      $display("FAIL stall: bad cycles %0d stb cycles %0d required 0 1", stall_bad, stb_cycles);
      n_bad++;
    end
    get_rsp(d, l, e, c);
    n_cmp++;
    if ({d, l, e} !== {32'h0000_0003, 1'b0, 1'b0}) begin
      $display("FAIL wrap_rsp0: data %h last %b err %b required 00000003 0 0", d, l, e);
      n_bad++;
    end
    get_rsp(d, l, e, c);
    n_cmp++;
    if ({d, l, e} !== {32'hFFFF_FFFF, 1'b1, 1'b0}) begin
      $display("FAIL wrap_rsp1: data %h last %b err %b required ffffffff 1 0", d, l, e);
      n_bad++;
    end
    n_cmp++;
    if (q_adr.size() != 2 || q_adr[1] !== 32'h0000_0000) begin
      $display("FAIL wrap_adr: beats %0d second adr %h required 2 00000000",
               q_adr.size(), (q_adr.size() > 1) ? q_adr[1] : 32'hX);
      n_bad++;
    end
  endtask

  task automatic test_reset_midburst();
    logic [31:0] d;
    logic l, e, c;
    int rst_bad;
    ack_after = 0;
    rst_bad = 0;
    issue_cmd(1'b0, 32'h3000_0300, 8'd2, 4'hF);
    tick();
    n_cmp++;
    if (stb !== 1'b1) begin
      $display("FAIL midburst_stb: stb got %b required 1", stb);
      n_bad++;
    end
    rst_n = 1'b0;
    force_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if ({cyc, stb, rsp_valid, busy} !== 4'b0000) rst_bad++;
    end
    n_cmp++;
    if (rst_bad != 0) begin
      $display("FAIL midburst_reset: %0d cycles with cyc/stb/rsp_valid/busy set, required 0", rst_bad);
      n_bad++;
    end
    force_ack = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0 || cyc !== 1'b0) begin
      $display("FAIL post_reset_quiet: rsp_valid %b cyc %b required 0 0", rsp_valid, cyc);
      n_bad++;
    end
    ack_after = 1;
    issue_cmd(1'b0, 32'h3000_0400, 8'd0, 4'hF);
    get_rsp(d, l, e, c);
    n_cmp++;
    if ({d, l, e} !== {~32'h3000_0400, 1'b1, 1'b0}) begin
      $display("FAIL post_reset_read: data %h last %b err %b required %h 1 0", d, l, e, ~32'h3000_0400);
      n_bad++;
    end
  endtask

  initial begin : main
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_we = 1'b0;
    cmd_adr = 32'h0;
    cmd_len = 8'd0;
    cmd_sel = 4'h0;
    wdata_valid = 1'b0;
    wdata = 32'h0;
    rsp_ready = 1'b0;
    test_reset();
    test_single_read();
    test_latency();
    test_read_burst();
    test_write_burst();
    test_timeout();
    test_back_to_back_wrap();
    test_reset_midburst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
